key_event_decoder: RTL and testbench

Consumer of the debounced key interface in the signal-generator control path. Takes the one-cycle press pulse (`key_flag`) and the debounced level (`key_state`, 0 = pressed) from the key debouncer. Classifies each gesture into short press, long press, auto-repeat and double click, each as a one-cycle event pulse for the waveform/frequency selection logic.

---
 rtl/key_event_decoder.sv | 160 ++++++++++++++++
 tb/tb_key_event_decoder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_decoder.sv
// Key gesture decoder: short/long/repeat/double-click pulses from a debounced key.
// Define KEY_DCLK_EN to build double-click detection (delays short_press by DCLK_CYC).
module key_event_decoder #(
  parameter int LONG_CYC   = 25_000_000,
  parameter int REPEAT_CYC = 5_000_000,
  parameter int DCLK_CYC   = 12_500_000,
  parameter int CNT_W      = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic key_flag,
  input  logic key_state,
  output logic short_press,
  output logic long_press,
  output logic repeat_tick,
  output logic double_click,
  output logic held
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRESS  = 3'd1,
    S_LONG   = 3'd2,
    S_WAIT2  = 3'd3,
    S_PRESS2 = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(REPEAT_CYC - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_ks;
  logic             r_entry;
  logic             w_rel;
  logic             w_long_tc;
  logic             w_rep_tc;
  logic             w_dclk_tc;
  logic             w_short;
  logic             w_long;
  logic             w_rep;
  logic             w_dbl;
  logic             w_held;

  // key_state lags key_flag: its first sample in a press state is stale
  assign w_rel     = r_ks & ~r_entry;
  assign w_long_tc = (r_cnt == LONG_TC);
  assign w_rep_tc  = (r_cnt == REP_TC);
`ifdef KEY_DCLK_EN
  assign w_dclk_tc = (r_cnt == CNT_W'(DCLK_CYC - 1));
`else
  assign w_dclk_tc = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ks    <= 1'b1;
      r_entry <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_ks    <= key_state;
      r_entry <= (w_next != r_state);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (key_flag) w_next = S_PRESS;
      end
      S_PRESS: begin
`ifdef KEY_DCLK_EN
        if (w_rel)          w_next = S_WAIT2;
`else
        if (w_rel)          w_next = S_IDLE;
`endif
        else if (w_long_tc) w_next = S_LONG;
      end
      S_LONG: begin
        if (r_ks) w_next = S_IDLE;
      end
`ifdef KEY_DCLK_EN
      S_WAIT2: begin
        if (key_flag)       w_next = S_PRESS2;
        else if (w_dclk_tc) w_next = S_IDLE;
      end
      S_PRESS2: begin
        if (w_rel) w_next = S_IDLE;
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nxt = '0;
    if (w_next == r_state) begin
      case (r_state)
        S_PRESS: w_cnt_nxt = r_cnt + CNT_W'(1);
        S_WAIT2: w_cnt_nxt = r_cnt + CNT_W'(1);
        S_LONG:  w_cnt_nxt = w_rep_tc ? '0 : r_cnt + CNT_W'(1);
        default: w_cnt_nxt = '0;
      endcase
    end
  end

  always_comb begin
    w_short = 1'b0;
    w_long  = 1'b0;
    w_rep   = 1'b0;
    w_dbl   = 1'b0;
    w_held  = 1'b0;
    case (r_state)
      S_PRESS: begin
        w_held = 1'b1;
        w_long = ~w_rel & w_long_tc;
`ifndef KEY_DCLK_EN
        w_short = w_rel;
`endif
      end
      S_LONG: begin
        w_held = 1'b1;
        w_rep  = ~r_ks & w_rep_tc;
      end
`ifdef KEY_DCLK_EN
      S_WAIT2: begin
        w_short = ~key_flag & w_dclk_tc;
      end
      S_PRESS2: begin
        w_held = 1'b1;
        w_dbl  = w_rel;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      repeat_tick  <= 1'b0;
      double_click <= 1'b0;
      held         <= 1'b0;
    end else begin
      short_press  <= w_short;
      long_press   <= w_long;
      repeat_tick  <= w_rep;
      double_click <= w_dbl;
      held         <= w_held;
    end
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: scoreboard of expected event pulses by cycle.
// Expectations follow KEY_DCLK_EN if it is defined for the build.
module tb_key_event_decoder;

  localparam int LC = 100;
  localparam int RC = 20;
  localparam int DC = 50;
`ifdef KEY_DCLK_EN
  localparam bit DCLK = 1'b1;
`else
  localparam bit DCLK = 1'b0;
`endif
  localparam int SDLY = DCLK ? DC + 2 : 2;

  localparam logic [3:0] EV_S = 4'b0001;
  localparam logic [3:0] EV_L = 4'b0010;
  localparam logic [3:0] EV_R = 4'b0100;
  localparam logic [3:0] EV_D = 4'b1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_flag = 1'b0;
  logic key_state = 1'b1;
  logic short_press;
  logic long_press;
  logic repeat_tick;
  logic double_click;
  logic held;

  typedef struct {
    int         c;
    logic [3:0] ev;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  logic prev_held = 1'b0;
  int   rise_c = -1;
  int   fall_c = -1;

  key_event_decoder #(
    .LONG_CYC  (LC),
    .REPEAT_CYC(RC),
    .DCLK_CYC  (DC),
    .CNT_W     (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_flag    (key_flag),
    .key_state   (key_state),
    .short_press (short_press),
    .long_press  (long_press),
    .repeat_tick (repeat_tick),
    .double_click(double_click),
    .held        (held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int c, input logic [3:0] ev);
    exp_t e;
    e.c  = c;
    e.ev = ev;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // key_flag this cycle, key_state low for hold cycles; r = first released cycle
  task automatic press(input int hold, output int r);
    key_flag = 1'b1;
    tick();
    key_flag  = 1'b0;
    key_state = 1'b0;
    repeat (hold) tick();
    key_state = 1'b1;
    r = cyc;
  endtask

  always @(negedge clk) begin
    logic [3:0] ev;
    logic [3:0] e;
    if (mon_en) begin
      ev = {double_click, repeat_tick, long_press, short_press};
      e  = 4'd0;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].c == cyc) begin
          e = e | q[i].ev;
          q.delete(i);
        end
      end
      if (ev !== 4'd0 || e != 4'd0)
        chk($sformatf("event@%0d", cyc), {28'd0, ev}, {28'd0, e});
      if (ev !== 4'd0)
        chk($sformatf("onehot@%0d", cyc), {31'd0, $onehot0(ev)}, 32'd1);
      if (held && !prev_held) rise_c = cyc;
      if (!held && prev_held) fall_c = cyc;
      prev_held = held;
    end
  end

  initial begin
    int t0;
    int r;
    int r1;
    int r2;

    idle(3);
    @(negedge clk);
    chk("rst_short", {31'd0, short_press}, 32'd0);
    chk("rst_long", {31'd0, long_press}, 32'd0);
    chk("rst_rep", {31'd0, repeat_tick}, 32'd0);
    chk("rst_dbl", {31'd0, double_click}, 32'd0);
    chk("rst_held", {31'd0, held}, 32'd0);
    rst = 1'b0;
    tick();
    mon_en = 1'b1;
    idle(2);

    // short press, hold 30
    t0 = cyc;
    press(30, r);
    push(r + SDLY, EV_S);
    idle(70);
    chk("held_rise", rise_c, t0 + 2);
    chk("held_fall", fall_c, r + 3);

    // long press with two repeats
    t0 = cyc;
    push(t0 + LC + 1, EV_L);
    push(t0 + LC + RC + 1, EV_R);
    push(t0 + LC + 2 * RC + 1, EV_R);
    press(150, r);
    idle(70);

    // release seen on the long terminal cycle: short, not long
    t0 = cyc;
    press(98, r);
    push(r + SDLY, EV_S);
    idle(70);

    // one cycle later: long press, nothing on release
    t0 = cyc;
    push(t0 + LC + 1, EV_L);
    press(99, r);
    idle(70);

    // release seen on the repeat terminal cycle: no repeat
    t0 = cyc;
    push(t0 + LC + 1, EV_L);
    press(118, r);
    idle(70);

    // second press 20 cycles after release
    press(10, r1);
    if (!DCLK) push(r1 + 2, EV_S);
    idle(20);
    press(10, r2);
    push(r2 + 2, DCLK ? EV_D : EV_S);
    idle(70);

    // second press on the last cycle of the window
    press(10, r1);
    if (!DCLK) push(r1 + 2, EV_S);
    idle(DC + 1);
    press(10, r2);
    push(r2 + 2, DCLK ? EV_D : EV_S);
    idle(70);

    // second press 60 cycles after release
    press(10, r1);
    push(r1 + SDLY, EV_S);
    idle(60);
    press(10, r2);
    push(r2 + SDLY, EV_S);
    idle(70);

    // reset mid-gesture
    t0 = cyc;
    push(t0 + LC + 1, EV_L);
    push(t0 + LC + RC + 1, EV_R);
    key_flag = 1'b1;
    tick();
    key_flag  = 1'b0;
    key_state = 1'b0;
    while (cyc < t0 + 130) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_short", {31'd0, short_press}, 32'd0);
    chk("mid_rst_long", {31'd0, long_press}, 32'd0);
    chk("mid_rst_rep", {31'd0, repeat_tick}, 32'd0);
    chk("mid_rst_dbl", {31'd0, double_click}, 32'd0);
    chk("mid_rst_held", {31'd0, held}, 32'd0);
    @(negedge clk);
    chk("post_rst_held", {31'd0, held}, 32'd0);
    while (cyc < t0 + 151) tick();
    key_state = 1'b1;
    idle(70);
    press(30, r);
    push(r + SDLY, EV_S);
    idle(70);

    idle(10);
    chk("sb_empty", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
